mos6502_ucode_seq: RTL
======================

Name: mos6502_ucode_seq

Overview:
- Parametrised microcode sequencer; next generation of the 6502 control decoder.
- Runs FETCH/DECODE/EXEC and walks a step counter through an external microcode ROM, addressed by {opcode, step}.
- Drives the registered control-line bus (register in/out enables, rw) to the datapath.
- Adds over the previous decoder: interrupt/reset injection (BRK-style), rdy read-stall, and step-overflow detection.

Parameters:
- CTRL_W, 16: control-bus width (one bit per register in/out enable).
- STEP_W, 3: microstep counter width.
- MAX_STEPS, 7: last legal step index; must be ≤ 2**STEP_W-1.
- FETCH_CTRL, 16'h0006: control word driven during FETCH (pcho|pclo).

Ports:
- clk  in  1  system clock; all state updates on falling edge.
- rst  in  1  reset, asynchronous, active-low.
- insn  in  8  opcode byte on data bus, sampled in DECODE.
- rdy  in  1  high = proceed; low stalls read cycles.
- nmi_n  in  1  NMI request, falling-edge triggered.
- irq_n  in  1  IRQ request, level, active-low.
- i_flag  in  1  IRQ mask from status register.
- ucode_ctrl  in  CTRL_W  ROM control word at uaddr.
- ucode_rw  in  1  ROM rw bit at uaddr (1 = write).
- ucode_last  in  1  ROM end-of-instruction bit at uaddr.
- uaddr  out  8+STEP_W  {opcode_q, step_q}, combinational from registers.
- ctrl  out  CTRL_W  registered control lines for the current cycle.
- rw  out  1  registered; 0 = read, 1 = write.
- sync  out  1  high during an opcode-fetch cycle.
- int_type  out  2  00 none, 01 IRQ, 10 NMI, 11 RESET; valid from DECODE until return to FETCH.
- ucode_err  out  1  sticky step-overflow flag.

Behaviour:
- Reset (rst low, async): state=FETCH, step_q=0, opcode_q=8'h00, ctrl=0, rw=0, sync=0, ucode_err=0, nmi_pend=0, rst_pend=1.
- FETCH edge: ctrl<=FETCH_CTRL, rw<=0, sync<=1, state<=DECODE.
- DECODE edge:
  - Select by priority rst_pend > nmi_pend > (irq_n==0 && i_flag==0).
  - If any is selected: opcode_q<=8'h00, int_type<=11/10/01, and clear that pend flag (IRQ has no flag).
  - Otherwise: opcode_q<=insn, int_type<=00.
  - Always: step_q<=0, ctrl<=0, rw<=0, sync<=0, state<=EXEC.
- EXEC edge:
  - ctrl<=ucode_ctrl, rw<=ucode_rw, sync<=0.
  - If ucode_last: state<=FETCH, step_q<=0, int_type<=00.
  - Else if step_q==MAX_STEPS: ucode_err<=1, state<=FETCH, step_q<=0.
  - Else step_q<=step_q+1.
- Rdy stall:
  - If rdy==0 and the current cycle is a read (rw==0), no register changes; ctrl and rw hold.
  - Write cycles (rw==1) ignore rdy.
  - The NMI edge detector keeps sampling during a stall.
- NMI: nmi_n sampled every falling edge. A 1→0 transition sets nmi_pend, held until serviced. A second edge while pending is absorbed; no queueing.
- IRQ: level only, evaluated in DECODE; deassertion before DECODE means no service.
- Simultaneous NMI edge and DECODE on the same edge: the new edge is not seen that DECODE; it is serviced at the next DECODE.
- Reset mid-EXEC aborts immediately. Post-reset first instruction is the BRK-style vector sequence with int_type=11.
- Latency: opcode byte to first EXEC control word = 2 cycles (FETCH, DECODE).

Optional Feature:
- Macro MOS6502_SO_EN.
- Defined: adds input so_n and output so_pulse. A falling edge on so_n produces a one-cycle so_pulse (set overflow), independent of state and rdy. so_pulse reset value 0.
- Undefined: neither port exists.

Decomposition:
- Package mos6502_ucode_pkg: state enum (FETCH, DECODE, EXEC); int_type enum (INT_NONE, INT_IRQ, INT_NMI, INT_RST); constant BRK_OPCODE=8'h00.
- Sub-module mos6502_int_latch: NMI edge detect, rst_pend/nmi_pend flags, priority resolve. Outputs the selected int_type to the sequencer and takes a service strobe from it.

Test Plan:
- Release reset, ROM ends at step 2 → FETCH, DECODE, 3 EXEC cycles. Requirements: uaddr=0x000..0x002; int_type=11 through EXEC; 2nd FETCH has sync=1 and ctrl=16'h0006.
- insn=8'hA9, ucode_last at step 1, ucode_ctrl=16'h1001 → uaddr 0x548, 0x549. Requirements: ctrl=16'h1001 in both EXEC cycles; back to FETCH after 4 cycles total.
- rdy=0 for 3 cycles during read step 1 → step_q, ctrl and uaddr frozen 3 cycles, then resume. With rdy=0 during a write step (ucode_rw=1), no stall occurs.
- irq_n=0 with i_flag=1 → normal opcode, int_type=00. irq_n=0 and nmi_n falling both before DECODE → opcode_q=00, int_type=10. IRQ is serviced at the following DECODE (int_type=01).
- ucode_last never asserted → after step 7 EXEC: ucode_err=1, return to FETCH. ucode_err stays 1 until rst low.
- rst pulsed low mid-EXEC step 3 → all outputs reset that instant; next sequence is the reset vector with int_type=11.

Source files
------------

// File: rtl/mos6502_ucode_pkg.sv
// ============================================================================
// Module      : mos6502_ucode_pkg
// Description : Shared types and constants for the 6502 microcode sequencer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mos6502_ucode_pkg;

    // Sequencer phase: opcode fetch, decode/interrupt injection, microcode walk
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } seq_state_t;

    // Source of the instruction currently executing
    typedef enum logic [1:0] {
        INT_NONE = 2'b00,
        INT_IRQ  = 2'b01,
        INT_NMI  = 2'b10,
        INT_RST  = 2'b11
    } int_type_t;

    // Opcode substituted when an interrupt or reset is injected
    localparam logic [7:0] BRK_OPCODE = 8'h00;

endpackage

`default_nettype wire

// File: rtl/mos6502_int_latch.sv
// ============================================================================
// Module      : mos6502_int_latch
// Description : NMI falling-edge detector, pending reset/NMI flags and
//               RESET > NMI > IRQ priority resolution for the sequencer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mos6502_int_latch
    import mos6502_ucode_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      nmi_n,
    input  logic      irq_n,
    input  logic      i_flag,
    input  logic      service,
    output int_type_t sel_type
);

    logic r_nmi_prev;
    logic r_nmi_pend;
    logic r_rst_pend;
    logic w_nmi_edge;

    assign w_nmi_edge = r_nmi_prev & ~nmi_n;

    // Sample NMI every edge (even while stalled); clear flags when serviced.
    // A fresh edge arriving on the servicing edge survives for the next DECODE.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_nmi_prev <= 1'b1;
            r_nmi_pend <= 1'b0;
            r_rst_pend <= 1'b1;
        end else begin
            r_nmi_prev <= nmi_n;
            r_nmi_pend <= (r_nmi_pend & ~(service && sel_type == INT_NMI)) | w_nmi_edge;
            if (service && sel_type == INT_RST) begin
                r_rst_pend <= 1'b0;
            end
        end
    end

    // Priority resolve from registered flags only, so a same-edge NMI waits
    always_comb begin
        sel_type = INT_NONE;
        if (r_rst_pend) begin
            sel_type = INT_RST;
        end else if (r_nmi_pend) begin
            sel_type = INT_NMI;
        end else if (!irq_n && !i_flag) begin
            sel_type = INT_IRQ;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mos6502_ucode_seq.sv
// ============================================================================
// Module      : mos6502_ucode_seq
// Description : Parametrised FETCH/DECODE/EXEC microcode sequencer driving
//               registered control lines; interrupt injection, rdy stall
//               on read cycles and sticky step-overflow detection.
//               Optional set-overflow pin support under MOS6502_SO_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mos6502_ucode_seq
    import mos6502_ucode_pkg::*;
#(
    parameter int                CTRL_W     = 16,
    parameter int                STEP_W     = 3,
    parameter int                MAX_STEPS  = 7,
    parameter logic [CTRL_W-1:0] FETCH_CTRL = CTRL_W'(16'h0006)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            insn,
    input  logic                  rdy,
    input  logic                  nmi_n,
    input  logic                  irq_n,
    input  logic                  i_flag,
    input  logic [CTRL_W-1:0]     ucode_ctrl,
    input  logic                  ucode_rw,
    input  logic                  ucode_last,
    output logic [8+STEP_W-1:0]   uaddr,
    output logic [CTRL_W-1:0]     ctrl,
    output logic                  rw,
    output logic                  sync,
    output logic [1:0]            int_type,
`ifdef MOS6502_SO_EN
    input  logic                  so_n,
    output logic                  so_pulse,
`endif
    output logic                  ucode_err
);

    seq_state_t        r_state,  w_state_nxt;
    logic [STEP_W-1:0] r_step,   w_step_nxt;
    logic [7:0]        r_opcode, w_opcode_nxt;
    logic [CTRL_W-1:0] r_ctrl,   w_ctrl_nxt;
    logic              r_rw,     w_rw_nxt;
    logic              r_sync,   w_sync_nxt;
    int_type_t         r_int,    w_int_nxt;
    logic              r_err,    w_err_nxt;
    logic              w_stall;
    logic              w_service;
    int_type_t         w_sel;

    // A read cycle with rdy low freezes the whole sequencer
    assign w_stall = ~rdy & ~r_rw;

    assign uaddr     = {r_opcode, r_step};
    assign ctrl      = r_ctrl;
    assign rw        = r_rw;
    assign sync      = r_sync;
    assign int_type  = r_int;
    assign ucode_err = r_err;

    mos6502_int_latch u_int_latch (
        .clk      (clk),
        .rst      (rst),
        .nmi_n    (nmi_n),
        .irq_n    (irq_n),
        .i_flag   (i_flag),
        .service  (w_service),
        .sel_type (w_sel)
    );

    // State and registered bus outputs, updated on the falling edge
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= FETCH;
            r_step   <= '0;
            r_opcode <= 8'h00;
            r_ctrl   <= '0;
            r_rw     <= 1'b0;
            r_sync   <= 1'b0;
            r_int    <= INT_NONE;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_step   <= w_step_nxt;
            r_opcode <= w_opcode_nxt;
            r_ctrl   <= w_ctrl_nxt;
            r_rw     <= w_rw_nxt;
            r_sync   <= w_sync_nxt;
            r_int    <= w_int_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next-state and next-output decode; everything holds while stalled
    always_comb begin
        w_state_nxt  = r_state;
        w_step_nxt   = r_step;
        w_opcode_nxt = r_opcode;
        w_ctrl_nxt   = r_ctrl;
        w_rw_nxt     = r_rw;
        w_sync_nxt   = r_sync;
        w_int_nxt    = r_int;
        w_err_nxt    = r_err;
        w_service    = 1'b0;
        if (!w_stall) begin
            case (r_state)
                FETCH: begin
                    w_ctrl_nxt  = FETCH_CTRL;
                    w_rw_nxt    = 1'b0;
                    w_sync_nxt  = 1'b1;
                    w_state_nxt = DECODE;
                end
                DECODE: begin
                    w_service    = 1'b1;
                    w_int_nxt    = w_sel;
                    w_opcode_nxt = (w_sel != INT_NONE) ? BRK_OPCODE : insn;
                    w_step_nxt   = '0;
                    w_ctrl_nxt   = '0;
                    w_rw_nxt     = 1'b0;
                    w_sync_nxt   = 1'b0;
                    w_state_nxt  = EXEC;
                end
                EXEC: begin
                    w_ctrl_nxt = ucode_ctrl;
                    w_rw_nxt   = ucode_rw;
                    w_sync_nxt = 1'b0;
                    if (ucode_last) begin
                        w_state_nxt = FETCH;
                        w_step_nxt  = '0;
                        w_int_nxt   = INT_NONE;
                    end else if (r_step == STEP_W'(MAX_STEPS)) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = FETCH;
                        w_step_nxt  = '0;
                    end else begin
                        w_step_nxt = r_step + STEP_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = FETCH;
                end
            endcase
        end
    end

`ifdef MOS6502_SO_EN
    logic r_so_prev;

    // One-cycle pulse on each so_n falling edge, regardless of state or rdy
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_so_prev <= 1'b1;
            so_pulse  <= 1'b0;
        end else begin
            r_so_prev <= so_n;
            so_pulse  <= r_so_prev & ~so_n;
        end
    end
`endif

endmodule

`default_nettype wire
